uart_byte_bridge: RTL

Buffered system-side endpoint for the byte-level req/ack handshake of the 921600-baud UART. It acknowledges received bytes from the UART and queues them in an RX FIFO for the system. It also queues system bytes in a TX FIFO and presents them to the UART transmitter one at a time. It sits between the UART and any consumer, so producers and consumers no longer have to keep up with the serial line byte by byte.

---
 rtl/uart_bridge_pkg.sv | 17 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/uart_byte_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART byte bridge: FSM state encodings and byte width.
package uart_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_ACK  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_REQ  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with registered pointers and occupancy count.
module byte_fifo
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BYTE_W-1:0]     din,
  output logic [BYTE_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [BYTE_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full/empty are judged on the registered count, so a push never bypasses to dout.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // NOTE: the storage is reset so the head byte reads 8'h00 out of reset; it costs a reset
  // net per bit, which is acceptable at this depth but not for large RAM-backed FIFOs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every read in this block
      // sees the pre-edge value, independent of statement order.
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_byte_bridge.sv
// Buffered bridge between the UART byte req/ack handshake and system valid/ready streams.
// Optional feature: define UART_BRIDGE_OVERRUN_EN to ack-and-drop bytes when the RX FIFO is full.
module uart_byte_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_100m,
  input  logic                  rst_n,
  input  logic [BYTE_W-1:0]     uart_rx_byte,
  input  logic                  uart_rx_req,
  output logic                  uart_rx_ack,
  output logic [BYTE_W-1:0]     uart_tx_byte,
  output logic                  uart_tx_req,
  input  logic                  uart_tx_ack,
  output logic [BYTE_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic [BYTE_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  rx_overrun,
  input  logic                  overrun_clr
);

  rx_state_t         rx_state;
  rx_state_t         rx_next;
  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic              rx_push;
  logic              rx_full;
  logic              rx_empty;
  logic              overrun_set;
  logic              tx_load;
  logic              tx_full;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk_100m),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (m_ready),
    .din   (uart_rx_byte),
    .dout  (m_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk_100m),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (tx_load),
    .din   (s_data),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign m_valid = !rx_empty;
  assign s_ready = !tx_full;

  // The ack pulse is exactly the single cycle spent in RX_ACK.
  assign uart_rx_ack = (rx_state == RX_ACK);
  // Derived from the async-reset state register, so the request drops the moment reset asserts.
  assign uart_tx_req = (tx_state == TX_REQ);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      tx_state     <= TX_IDLE;
      uart_tx_byte <= '0;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
      if (tx_load) begin
        uart_tx_byte <= tx_head;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    rx_next     = rx_state;
    rx_push     = 1'b0;
    overrun_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (uart_rx_req) begin
          if (!rx_full) begin
            rx_push = 1'b1;
            rx_next = RX_ACK;
          end
`ifdef UART_BRIDGE_OVERRUN_EN
          else begin
            overrun_set = 1'b1;
            rx_next     = RX_ACK;
          end
`endif
        end
      end
      RX_ACK:  rx_next = RX_WAIT;
      RX_WAIT: if (!uart_rx_req) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_load = 1'b1;
          tx_next = TX_REQ;
        end
      end
      TX_REQ:  if (uart_tx_ack) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

`ifdef UART_BRIDGE_OVERRUN_EN
  // Set has priority so an overrun in the same cycle as a clear is never lost.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
    end else if (overrun_set) begin
      rx_overrun <= 1'b1;
    end else if (overrun_clr) begin
      rx_overrun <= 1'b0;
    end
  end
`else
  logic unused_overrun;
  assign unused_overrun = ^{overrun_clr, overrun_set};
  assign rx_overrun     = 1'b0;
`endif

endmodule
